// File: rtl/alu_stateful_v2.sv
// Stateful RMT action-stage ALU with a tenant-partitioned private state RAM.
// Define ALU_SATURATE_EN for saturating add/sub/loadd/fetch-add; the default build wraps modulo 2**DATA_WIDTH.
module alu_stateful_v2 #(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACTION_LEN-1:0]   action_in,
    input  logic                    action_valid,
    input  logic [DATA_WIDTH-1:0]   operand_1_in,
    input  logic [DATA_WIDTH-1:0]   operand_2_in,
    input  logic [DATA_WIDTH-1:0]   operand_3_in,
    output logic                    ready_out,
    input  logic [2*ADDR_WIDTH-1:0] page_tbl_in,
    output logic [DATA_WIDTH-1:0]   container_out,
    output logic                    container_out_valid,
    output logic                    overflow_out,
    input  logic                    ready_in
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] EX   = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    function automatic logic [DATA_WIDTH-1:0] add_fn(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef ALU_SATURATE_EN
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sub_fn(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef ALU_SATURATE_EN
        return (a < b) ? '0 : a - b;
`else
        return a - b;
`endif
    endfunction

    logic [1:0]            state;
    logic [3:0]            opcode_p0;
    logic [DATA_WIDTH-1:0] op1_p0;
    logic [DATA_WIDTH-1:0] op2_p0;
    logic [DATA_WIDTH-1:0] op3_p0;
    logic [ADDR_WIDTH-1:0] base_p0;
    logic [ADDR_WIDTH-1:0] len_p0;
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] phys;
    logic                  out_of_range;
    logic [DATA_WIDTH-1:0] res;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  ranged;
    logic                  ovf_hit;
    logic                  unused_bits;

    assign unused_bits  = ^{action_in[ACTION_LEN-5:0], STAGE_ID != 0};
    assign ready_out    = (state == IDLE);
    assign accept       = action_valid && ready_out;
    assign offset       = op2_p0[ADDR_WIDTH-1:0];
    assign phys         = base_p0 + offset;
    assign out_of_range = offset > len_p0;

    // Accept: capture the action and page entry; later page_tbl_in changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_p0 <= action_in[ACTION_LEN-1 -: 4];
            op1_p0    <= operand_1_in;
            op2_p0    <= operand_2_in;
            op3_p0    <= operand_3_in;
            base_p0   <= page_tbl_in[ADDR_WIDTH-1:0];
            len_p0    <= page_tbl_in[2*ADDR_WIDTH-1:ADDR_WIDTH];
        end
    end

    // RD -> EX: registered RAM read; EX -> OUT: commit write (abandoned if reset hits first)
    always_ff @(posedge clk) begin
        if (state == RD) begin
            rdata_p1 <= mem[phys];
        end
        if (state == EX && wr_en) begin
            mem[phys] <= wr_data;
        end
    end

    always_comb begin
        res     = op3_p0;
        wr_data = op1_p0;
        wr_en   = 1'b0;
        ranged  = 1'b0;
        case (opcode_p0)
            4'b0001, 4'b1001: res = add_fn(op1_p0, op2_p0);
            4'b0010, 4'b1010: res = sub_fn(op1_p0, op2_p0);
            4'b0100:          res = op1_p0 & op2_p0;
            4'b0101:          res = op1_p0 | op2_p0;
            4'b0110:          res = {{(DATA_WIDTH-1){1'b0}}, op1_p0 >= op2_p0};
            4'b1110:          res = op2_p0;
            4'b1011: begin
                ranged = 1'b1;
                res    = rdata_p1;
            end
            4'b0111: begin
                ranged  = 1'b1;
                res     = add_fn(rdata_p1, DATA_WIDTH'(1));
                wr_data = res;
                wr_en   = 1'b1;
            end
            4'b1100: begin
                ranged  = 1'b1;
                res     = rdata_p1;
                wr_data = add_fn(rdata_p1, op1_p0);
                wr_en   = 1'b1;
            end
            4'b1000: begin
                ranged = 1'b1;
                wr_en  = 1'b1;
            end
            4'b0011:          wr_en = 1'b1;
            default:          res = op3_p0;
        endcase
        // Out-of-tenant access: suppress the write and pass the container through
        ovf_hit = ranged && out_of_range;
        if (ovf_hit) begin
            res   = op3_p0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            container_out       <= '0;
            container_out_valid <= 1'b0;
            overflow_out        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) state <= RD;
                RD:   state <= EX;
                EX: begin
                    state               <= OUT;
                    container_out       <= res;
                    overflow_out        <= ovf_hit;
                    container_out_valid <= 1'b1;
                end
                OUT: begin
                    if (ready_in) begin
                        state               <= IDLE;
                        container_out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stateful_v2.sv
// Scoreboard bench for alu_stateful_v2: directed transactions push expected results, a monitor pops on each output handshake.
module tb_alu_stateful_v2;

    localparam logic [3:0] OP_ADD = 4'b0001, OP_ADDI = 4'b1001, OP_SUB = 4'b0010, OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b0100, OP_OR = 4'b0101, OP_GEQ = 4'b0110, OP_SET = 4'b1110;
    localparam logic [3:0] OP_LOAD = 4'b1011, OP_LOADD = 4'b0111, OP_FADD = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1000, OP_STOREI = 4'b0011, OP_NOP = 4'b1111;

`ifdef ALU_SATURATE_EN
    localparam logic [31:0] E_FADD_LOAD = 32'hFFFF_FFFF;
    localparam logic [31:0] E_LOADD_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] E_ADD_OVF = 32'hFFFF_FFFF;
    localparam logic [31:0] E_SUB_UNDER = 32'h0;
`else
    localparam logic [31:0] E_FADD_LOAD = 32'h1;
    localparam logic [31:0] E_LOADD_ONES = 32'h0;
    localparam logic [31:0] E_ADD_OVF = 32'h1;
    localparam logic [31:0] E_SUB_UNDER = 32'hFFFF_FFF9;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] action_in = '0;
    logic        action_valid = 1'b0;
    logic [31:0] operand_1_in = '0, operand_2_in = '0, operand_3_in = '0;
    logic        ready_out;
    logic [9:0]  page_tbl_in = '0;
    logic [31:0] container_out;
    logic        container_out_valid;
    logic        overflow_out;
    logic        ready_in = 1'b1;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        string       name;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    alu_stateful_v2 dut (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
        .ready_out(ready_out), .page_tbl_in(page_tbl_in), .container_out(container_out),
        .container_out_valid(container_out_valid), .overflow_out(overflow_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare on every accepted output beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && container_out_valid && ready_in) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", container_out);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"}, 64'(container_out), 64'(e.data));
                    chk({e.name, "_ovf"}, 64'(overflow_out), 64'(e.ovf));
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_out) chk({name, "_ready_timeout"}, 64'(ready_out), 64'd1);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] o3, input logic [4:0] base, input logic [4:0] len);
        action_in    = {op, 21'h0};
        operand_1_in = o1;
        operand_2_in = o2;
        operand_3_in = o3;
        page_tbl_in  = {len, base};
        action_valid = 1'b1;
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        operand_1_in = 32'hA5A5_A5A5;
        operand_2_in = 32'h5A5A_5A5A;
        operand_3_in = 32'hC3C3_C3C3;
        page_tbl_in  = '1;
    endtask

    task automatic txn(input string name, input logic [3:0] op, input logic [31:0] o1,
                       input logic [31:0] o2, input logic [31:0] o3, input logic [4:0] base,
                       input logic [4:0] len, input logic [31:0] ed, input logic eo, input int hold);
        exp_t e;
        int n, bad;
        logic rdy_rd;
        logic [31:0] v;
        e.data = ed;
        e.ovf  = eo;
        e.name = name;
        wait_ready(name);
        sb.push_back(e);
        ready_in = (hold == 0);
        drive(op, o1, o2, o3, base, len);
        n = 0;
        rdy_rd = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) rdy_rd = ready_out;
        end while (!container_out_valid && n < 10);
        chk({name, "_latency"}, 64'(n), 64'd3);
        chk({name, "_ready_low"}, 64'(rdy_rd), 64'd0);
        if (hold > 0) begin
            v = container_out;
            bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (!container_out_valid || container_out !== v || ready_out) bad++;
            end
            chk({name, "_hold_stable"}, 64'(bad), 64'd0);
            @(posedge clk);
            #1;
            ready_in = 1'b1;
            @(posedge clk);
            #1;
            ready_in = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
        chk({name, "_ready_back"}, 64'(ready_out), 64'd1);
        chk({name, "_valid_drop"}, 64'(container_out_valid), 64'd0);
        ready_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_valid", 64'(container_out_valid), 64'd0);
        chk("rst_data", 64'(container_out), 64'd0);
        chk("rst_ovf", 64'(overflow_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load
        txn("store1", OP_STORE, 32'hDEAD_BEEF, 32'd3, 32'h11, 5'd4, 5'd8, 32'h11, 1'b0, 0);
        txn("load1", OP_LOAD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'hDEAD_BEEF, 1'b0, 0);
        // loadd chain
        txn("store5", OP_STORE, 32'd5, 32'd3, 32'h22, 5'd4, 5'd8, 32'h22, 1'b0, 0);
        txn("loadd1", OP_LOADD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'd6, 1'b0, 0);
        txn("loadd2", OP_LOADD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'd7, 1'b0, 0);
        txn("loadd3", OP_LOADD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'd8, 1'b0, 0);
        txn("load8", OP_LOAD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'd8, 1'b0, 0);
        // Out-of-range accesses leave RAM untouched
        txn("ovf_load", OP_LOAD, 32'h0, 32'd3, 32'h55, 5'd4, 5'd2, 32'h55, 1'b1, 0);
        txn("ovf_store", OP_STORE, 32'h99, 32'd3, 32'h66, 5'd4, 5'd2, 32'h66, 1'b1, 0);
        txn("ovf_loadd", OP_LOADD, 32'h0, 32'd3, 32'h67, 5'd4, 5'd2, 32'h67, 1'b1, 0);
        txn("load_after_ovf", OP_LOAD, 32'h0, 32'd3, 32'h0, 5'd4, 5'd8, 32'd8, 1'b0, 0);
        // Backpressure
        txn("bp_add", OP_ADD, 32'd10, 32'd20, 32'h0, 5'd0, 5'd0, 32'd30, 1'b0, 10);
        // Plain ALU ops
        txn("sub", OP_SUB, 32'd10, 32'd3, 32'h0, 5'd0, 5'd0, 32'd7, 1'b0, 0);
        txn("sub_under", OP_SUB, 32'd3, 32'd10, 32'h0, 5'd0, 5'd0, E_SUB_UNDER, 1'b0, 0);
        txn("subi", OP_SUBI, 32'd5, 32'd1, 32'h0, 5'd0, 5'd0, 32'd4, 1'b0, 0);
        txn("addi", OP_ADDI, 32'd1, 32'd1, 32'h0, 5'd0, 5'd0, 32'd2, 1'b0, 0);
        txn("add_ovf", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd0, 5'd0, E_ADD_OVF, 1'b0, 0);
        txn("and", OP_AND, 32'hF0F0, 32'hFF00, 32'h0, 5'd0, 5'd0, 32'hF000, 1'b0, 0);
        txn("or", OP_OR, 32'hF0F0, 32'hFF00, 32'h0, 5'd0, 5'd0, 32'hFFF0, 1'b0, 0);
        txn("geq_t", OP_GEQ, 32'd5, 32'd3, 32'h0, 5'd0, 5'd0, 32'd1, 1'b0, 0);
        txn("geq_f", OP_GEQ, 32'd3, 32'd5, 32'h0, 5'd0, 5'd0, 32'd0, 1'b0, 0);
        txn("set", OP_SET, 32'd9, 32'h1234, 32'h0, 5'd0, 5'd0, 32'h1234, 1'b0, 0);
        txn("nop", OP_NOP, 32'd9, 32'd9, 32'h77, 5'd0, 5'd0, 32'h77, 1'b0, 0);
        // Fetch-add and loadd at all-ones
        txn("store_ones", OP_STORE, 32'hFFFF_FFFF, 32'd0, 32'h1, 5'd4, 5'd8, 32'h1, 1'b0, 0);
        txn("fadd", OP_FADD, 32'd2, 32'd0, 32'h0, 5'd4, 5'd8, 32'hFFFF_FFFF, 1'b0, 0);
        txn("load_fadd", OP_LOAD, 32'h0, 32'd0, 32'h0, 5'd4, 5'd8, E_FADD_LOAD, 1'b0, 0);
        txn("store_ones2", OP_STORE, 32'hFFFF_FFFF, 32'd1, 32'h2, 5'd4, 5'd8, 32'h2, 1'b0, 0);
        txn("loadd_ones", OP_LOADD, 32'h0, 32'd1, 32'h0, 5'd4, 5'd8, E_LOADD_ONES, 1'b0, 0);
        // Physical address wrap: base 30 + offset 3 -> 1
        txn("store_wrap", OP_STORE, 32'hCAFE, 32'd3, 32'h3, 5'd30, 5'd8, 32'h3, 1'b0, 0);
        txn("load_wrap", OP_LOAD, 32'h0, 32'd1, 32'h0, 5'd0, 5'd31, 32'hCAFE, 1'b0, 0);
        // storei ignores the range check
        txn("storei", OP_STOREI, 32'hBEEF, 32'd9, 32'h33, 5'd0, 5'd0, 32'h33, 1'b0, 0);
        txn("load_storei", OP_LOAD, 32'h0, 32'd0, 32'h0, 5'd9, 5'd0, 32'hBEEF, 1'b0, 0);

        // Reset during RD of a store: write abandoned
        wait_ready("rst_store");
        drive(OP_STORE, 32'h1111, 32'd9, 32'h44, 5'd0, 5'd31);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready_out), 64'd1);
        chk("midrst_valid", 64'(container_out_valid), 64'd0);
        chk("midrst_data", 64'(container_out), 64'd0);
        chk("midrst_ovf", 64'(overflow_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn("load_after_rst", OP_LOAD, 32'h0, 32'd9, 32'h0, 5'd0, 5'd31, 32'hBEEF, 1'b0, 0);

        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
